cga_palette_ctrl: RTL and testbench

//  Programmable 16-entry palette for CGA video. Replaces the fixed 4-bit-to-18-bit colour map.
//  A CPU I/O port sequences palette writes and reads, VGA-DAC style: index, then R, G, B.

---
 rtl/cga_pkg.sv | 64 ++++++
 rtl/cga_palette_ram.sv | 58 +++++
 rtl/cga_palette_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cga_palette_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cga_pkg.sv
// Shared definitions for the CGA programmable palette: CPU port address map,
// sequencer phase encoding and the power-on CGA colour table.
package cga_pkg;

  // Component width the stock CGA table is expressed in.
  localparam int DEFAULT_COLOR_W = 6;

  // CPU I/O port register map (io_addr).
  localparam logic [1:0] IO_WIDX = 2'd0;
  localparam logic [1:0] IO_RIDX = 2'd1;
  localparam logic [1:0] IO_DATA = 2'd2;
  localparam logic [1:0] IO_MASK = 2'd3;

  // Which colour component the next data access addresses.
  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // CGA only ever uses four intensity levels per component. The table is
  // stored as levels so the RAM can expand them to any component width.
  localparam logic [1:0] LVL_00 = 2'd0;  // all zeros
  localparam logic [1:0] LVL_15 = 2'd1;  // 010101 pattern
  localparam logic [1:0] LVL_2A = 2'd2;  // 101010 pattern
  localparam logic [1:0] LVL_3F = 2'd3;  // all ones

  // R -> G -> B -> R rotation shared by the write and read sequencers.
  function automatic phase_e nextPhase(input phase_e ph);
    phase_e result;
    case (ph)
      PH_R:    result = PH_G;
      PH_G:    result = PH_B;
      default: result = PH_R;
    endcase
    return result;
  endfunction

  // Default CGA palette as {R,G,B} intensity levels; entry 6 is the brown
  // special case with a half-intensity green.
  function automatic logic [5:0] cgaDefaultLevels(input logic [3:0] idx);
    logic [5:0] lv;
    case (idx)
      4'h0:    lv = {LVL_00, LVL_00, LVL_00};
      4'h1:    lv = {LVL_00, LVL_00, LVL_2A};
      4'h2:    lv = {LVL_00, LVL_2A, LVL_00};
      4'h3:    lv = {LVL_00, LVL_2A, LVL_2A};
      4'h4:    lv = {LVL_2A, LVL_00, LVL_00};
      4'h5:    lv = {LVL_2A, LVL_00, LVL_2A};
      4'h6:    lv = {LVL_2A, LVL_15, LVL_00};
      4'h7:    lv = {LVL_2A, LVL_2A, LVL_2A};
      4'h8:    lv = {LVL_15, LVL_15, LVL_15};
      4'h9:    lv = {LVL_15, LVL_15, LVL_3F};
      4'hA:    lv = {LVL_15, LVL_3F, LVL_15};
      4'hB:    lv = {LVL_15, LVL_3F, LVL_3F};
      4'hC:    lv = {LVL_3F, LVL_15, LVL_15};
      4'hD:    lv = {LVL_3F, LVL_15, LVL_3F};
      4'hE:    lv = {LVL_3F, LVL_3F, LVL_15};
      default: lv = {LVL_3F, LVL_3F, LVL_3F};
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/cga_palette_ram.sv
// 16-entry palette storage: one synchronous write port, two combinational
// read ports (pixel path and CPU read-back), reset loads the CGA colours.
module cga_palette_ram #(
  parameter int COLOR_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [3:0]           waddr_i,
  input  logic [3*COLOR_W-1:0] wdata_i,
  input  logic [3:0]           pixAddr_i,
  output logic [3*COLOR_W-1:0] pixData_o,
  input  logic [3:0]           cpuAddr_i,
  output logic [3*COLOR_W-1:0] cpuData_o
);
  import cga_pkg::*;

  logic [3*COLOR_W-1:0] mem_q [16];

  // Turn an intensity level into a component of the configured width; the
  // 15/2A patterns alternate bits so they stay roughly 1/3 and 2/3 scale.
  function automatic logic [COLOR_W-1:0] expandLevel(input logic [1:0] lvl);
    logic [COLOR_W-1:0] v;
    for (int b = 0; b < COLOR_W; b++) begin
      case (lvl)
        LVL_15:  v[b] = ((b % 2) == 0);
        LVL_2A:  v[b] = ((b % 2) == 1);
        LVL_3F:  v[b] = 1'b1;
        default: v[b] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [3*COLOR_W-1:0] defaultEntry(input logic [3:0] idx);
    logic [5:0] lv;
    lv = cgaDefaultLevels(idx);
    return {expandLevel(lv[5:4]), expandLevel(lv[3:2]), expandLevel(lv[1:0])};
  endfunction

  // Palette flops: reset restores the CGA table, otherwise one entry per
  // clock may be overwritten by the CPU sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= defaultEntry(4'(i));
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Both read ports see the pre-write contents during a commit cycle, so a
  // pixel hitting the entry being written gets the old colour.
  assign pixData_o = mem_q[pixAddr_i];
  assign cpuData_o = mem_q[cpuAddr_i];

endmodule

// File: rtl/cga_palette_ctrl.sv
// Programmable CGA palette: VGA-DAC style CPU port (index, then R,G,B) plus
// a free-running pixel lookup with one clock of latency.
module cga_palette_ctrl #(
  parameter int COLOR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         io_addr,
  input  logic               io_wr,
  input  logic               io_rd,
  input  logic [7:0]         io_din,
  output logic [7:0]         io_dout,
  input  logic [3:0]         video,
  input  logic               blank,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);
  import cga_pkg::*;

  localparam int ENTRY_W = 3 * COLOR_W;

  logic [3:0]         widx_q, widx_d;
  logic [3:0]         ridx_q, ridx_d;
  phase_e             wph_q, wph_d;
  phase_e             rph_q, rph_d;
  logic [COLOR_W-1:0] stagedR_q, stagedR_d;
  logic [COLOR_W-1:0] stagedG_q, stagedG_d;
  logic [3:0]         mask_q, mask_d;
  logic [7:0]         dout_q, dout_d;
  logic [ENTRY_W-1:0] rgb_q, rgb_d;

  logic               palWe;
  logic [ENTRY_W-1:0] palWdata;
  logic [3:0]         pixIdx;
  logic [ENTRY_W-1:0] pixEntry;
  logic [ENTRY_W-1:0] cpuEntry;
  logic [COLOR_W-1:0] cpuComp;
  logic [COLOR_W-1:0] dinColor;
  logic               unusedDinHi;

  assign dinColor    = io_din[COLOR_W-1:0];
  assign unusedDinHi = ^io_din[7:COLOR_W];

  // The final data write of a triple commits the staged R and G together
  // with the incoming B in a single cycle.
  assign palWdata = {stagedR_q, stagedG_q, dinColor};
  assign pixIdx   = video & mask_q;

  cga_palette_ram #(
    .COLOR_W (COLOR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we_i      (palWe),
    .waddr_i   (widx_q),
    .wdata_i   (palWdata),
    .pixAddr_i (pixIdx),
    .pixData_o (pixEntry),
    .cpuAddr_i (ridx_q),
    .cpuData_o (cpuEntry)
  );

  // Pick the component of the read-index entry that the read phase points at.
  always_comb begin
    case (rph_q)
      PH_R:    cpuComp = cpuEntry[3*COLOR_W-1:2*COLOR_W];
      PH_G:    cpuComp = cpuEntry[2*COLOR_W-1:COLOR_W];
      default: cpuComp = cpuEntry[COLOR_W-1:0];
    endcase
  end

  // CPU port sequencer: a write strobe takes priority over a read strobe, and
  // the write and read phase counters advance independently of each other.
  always_comb begin
    widx_d    = widx_q;
    ridx_d    = ridx_q;
    wph_d     = wph_q;
    rph_d     = rph_q;
    stagedR_d = stagedR_q;
    stagedG_d = stagedG_q;
    mask_d    = mask_q;
    dout_d    = dout_q;
    palWe     = 1'b0;
    if (io_wr) begin
      case (io_addr)
        IO_WIDX: begin
          widx_d    = io_din[3:0];
          wph_d     = PH_R;
          stagedR_d = '0;
          stagedG_d = '0;
        end
        IO_RIDX: begin
          ridx_d = io_din[3:0];
          rph_d  = PH_R;
        end
        IO_DATA: begin
          case (wph_q)
            PH_R: stagedR_d = dinColor;
            PH_G: stagedG_d = dinColor;
            default: begin
              palWe  = 1'b1;
              widx_d = widx_q + 4'd1;
            end
          endcase
          wph_d = nextPhase(wph_q);
        end
        default: mask_d = io_din[3:0];
      endcase
    end else if (io_rd) begin
      case (io_addr)
        IO_WIDX: dout_d = {4'b0, widx_q};
        IO_RIDX: dout_d = {4'b0, ridx_q};
        IO_DATA: begin
          dout_d = 8'(cpuComp);
          rph_d  = nextPhase(rph_q);
          if (rph_q == PH_B) begin
            ridx_d = ridx_q + 4'd1;
          end
        end
        default: dout_d = {4'b0, mask_q};
      endcase
    end
  end

  // Blanking forces black ahead of the output register so the DAC sees a
  // clean zero on exactly the same cycle as the colour would have appeared.
  assign rgb_d = blank ? '0 : pixEntry;

  // Sequencer state, mask, read-back and pixel output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      widx_q    <= '0;
      ridx_q    <= '0;
      wph_q     <= PH_R;
      rph_q     <= PH_R;
      stagedR_q <= '0;
      stagedG_q <= '0;
      mask_q    <= 4'hF;
      dout_q    <= '0;
      rgb_q     <= '0;
    end else begin
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      wph_q     <= wph_d;
      rph_q     <= rph_d;
      stagedR_q <= stagedR_d;
      stagedG_q <= stagedG_d;
      mask_q    <= mask_d;
      dout_q    <= dout_d;
      rgb_q     <= rgb_d;
    end
  end

  assign io_dout = dout_q;
  assign red     = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign green   = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue    = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_cga_palette_ctrl.sv
// Directed bench for the CGA palette: defaults, write/read sequencing,
// index wrap, partial-triple discard, masking, blanking and async reset.
module tb_cga_palette_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] io_addr;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic [3:0] video;
  logic       blank;
  logic [5:0] red;
  logic [5:0] green;
  logic [5:0] blue;

  int testsRun;
  int testsFailed;

  cga_palette_ctrl #(
    .COLOR_W (6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_addr (io_addr),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_din  (io_din),
    .io_dout (io_dout),
    .video   (video),
    .blank   (blank),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-written default CGA colours as {R,G,B}.
  function automatic logic [17:0] refRgb(input logic [3:0] v);
    logic [17:0] r;
    case (v)
      4'h0:    r = {6'h00, 6'h00, 6'h00};
      4'h1:    r = {6'h00, 6'h00, 6'h2A};
      4'h2:    r = {6'h00, 6'h2A, 6'h00};
      4'h3:    r = {6'h00, 6'h2A, 6'h2A};
      4'h4:    r = {6'h2A, 6'h00, 6'h00};
      4'h5:    r = {6'h2A, 6'h00, 6'h2A};
      4'h6:    r = {6'h2A, 6'h15, 6'h00};
      4'h7:    r = {6'h2A, 6'h2A, 6'h2A};
      4'h8:    r = {6'h15, 6'h15, 6'h15};
      4'h9:    r = {6'h15, 6'h15, 6'h3F};
      4'hA:    r = {6'h15, 6'h3F, 6'h15};
      4'hB:    r = {6'h15, 6'h3F, 6'h3F};
      4'hC:    r = {6'h3F, 6'h15, 6'h15};
      4'hD:    r = {6'h3F, 6'h15, 6'h3F};
      4'hE:    r = {6'h3F, 6'h3F, 6'h15};
      default: r = {6'h3F, 6'h3F, 6'h3F};
    endcase
    return r;
  endfunction

  // Drive one CPU access for exactly one clock; called and returns on a negedge.
  task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] din,
                               input logic wr, input logic rd);
    io_addr = addr;
    io_din  = din;
    io_wr   = wr;
    io_rd   = rd;
    @(negedge clk);
    io_wr   = 1'b0;
    io_rd   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present a pixel index, let it pass the output register, check the colour.
  task automatic checkPixel(input string tag, input logic [3:0] v,
                            input logic [17:0] expected);
    video = v;
    @(negedge clk);
    checkOutput(tag, {14'b0, red, green, blue}, {14'b0, expected});
  endtask

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset   = 1'b1;
    io_addr = 2'd0;
    io_wr   = 1'b0;
    io_rd   = 1'b0;
    io_din  = 8'h00;
    video   = 4'h0;
    blank   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_rgb", {14'b0, red, green, blue}, 32'h0);
    checkOutput("reset_dout", {24'b0, io_dout}, 32'h0);
    reset = 1'b0;

    // 1. Default palette sweep.
    for (int v = 0; v < 16; v++) begin
      checkPixel($sformatf("default_%0h", v), 4'(v), refRgb(4'(v)));
    end
    applyStimulus(2'd3, 8'h00, 1'b0, 1'b1);
    checkOutput("reset_mask", {24'b0, io_dout}, 32'h0F);
    applyStimulus(2'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("reset_widx", {24'b0, io_dout}, 32'h00);

    // 2. Program entry 3.
    applyStimulus(2'd0, 8'h03, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h3F, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h00, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h15, 1'b1, 1'b0);
    checkPixel("pal3_written", 4'h3, {6'h3F, 6'h00, 6'h15});
    applyStimulus(2'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("widx_after_3", {24'b0, io_dout}, 32'h04);

    // 3. Write index wraps from F to 0.
    applyStimulus(2'd0, 8'h0F, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h01, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h02, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h03, 1'b1, 1'b0);
    applyStimulus(2'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("widx_wrap", {24'b0, io_dout}, 32'h00);
    applyStimulus(2'd2, 8'h04, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h05, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h06, 1'b1, 1'b0);
    checkPixel("palF_written", 4'hF, {6'h01, 6'h02, 6'h03});
    checkPixel("pal0_after_wrap", 4'h0, {6'h04, 6'h05, 6'h06});

    // 4. Partial triple discarded by a new write index.
    applyStimulus(2'd0, 8'h02, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h11, 1'b1, 1'b0);
    applyStimulus(2'd0, 8'h05, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h07, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h08, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h09, 1'b1, 1'b0);
    checkPixel("pal2_untouched", 4'h2, {6'h00, 6'h2A, 6'h00});
    checkPixel("pal5_written", 4'h5, {6'h07, 6'h08, 6'h09});

    // 5. Read back entry 6, with a simultaneous wr+rd in the middle.
    applyStimulus(2'd1, 8'h06, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h00, 1'b0, 1'b1);
    checkOutput("read6_r", {24'b0, io_dout}, 32'h2A);
    applyStimulus(2'd3, 8'h0F, 1'b1, 1'b1);
    checkOutput("wr_rd_dout_held", {24'b0, io_dout}, 32'h2A);
    applyStimulus(2'd2, 8'h00, 1'b0, 1'b1);
    checkOutput("read6_g", {24'b0, io_dout}, 32'h15);
    applyStimulus(2'd2, 8'h00, 1'b0, 1'b1);
    checkOutput("read6_b", {24'b0, io_dout}, 32'h00);
    applyStimulus(2'd1, 8'h00, 1'b0, 1'b1);
    checkOutput("ridx_after_read", {24'b0, io_dout}, 32'h07);

    // 6. Mask, blank, and async reset in the middle of a triple.
    applyStimulus(2'd3, 8'h07, 1'b1, 1'b0);
    checkPixel("mask7_videoF", 4'hF, {6'h2A, 6'h2A, 6'h2A});
    blank = 1'b1;
    checkPixel("blank", 4'hF, 18'h0);
    blank = 1'b0;
    checkPixel("unblank", 4'h7, {6'h2A, 6'h2A, 6'h2A});
    applyStimulus(2'd0, 8'h07, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h01, 1'b1, 1'b0);
    applyStimulus(2'd2, 8'h02, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_rgb", {14'b0, red, green, blue}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'd2, 8'h03, 1'b1, 1'b0);
    checkPixel("pal7_after_reset", 4'h7, {6'h2A, 6'h2A, 6'h2A});
    checkPixel("pal0_restored", 4'h0, 18'h0);
    checkPixel("palF_restored", 4'hF, {6'h3F, 6'h3F, 6'h3F});
    checkPixel("pal3_restored", 4'h3, {6'h00, 6'h2A, 6'h2A});
    applyStimulus(2'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("widx_after_reset", {24'b0, io_dout}, 32'h00);
    applyStimulus(2'd3, 8'h00, 1'b0, 1'b1);
    checkOutput("mask_after_reset", {24'b0, io_dout}, 32'h0F);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
